// File: rtl/calc_pkg.sv
// Shared calculator definitions: ASCII frame constants, encoder state type and
// the nibble-to-ASCII helper used by result_encoder.
package calc_pkg;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_A     = 8'h41;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_SPACE,
    S_SIGN,
    S_DIGIT,
    S_ERR,
    S_CR,
    S_LF
  } enc_state_e;

  // Hex digit as upper-case ASCII: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
    if (n <= 4'd9) return ASC_ZERO + {4'h0, n};
    else           return ASC_A + ({4'h0, n} - 8'd10);
  endfunction

endpackage

// File: rtl/result_encoder_if.sv
// Result-in / byte-out bundle between the calculator core, the encoder and the
// UART transmitter. master drives results and tx_ready; slave is the encoder.
interface result_encoder_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] result;
  logic                result_neg;
  logic                result_err;
  logic                result_valid;
  logic                result_ready;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                busy;
  logic                frame_done;

  modport master (
    output result, result_neg, result_err, result_valid, tx_ready,
    input  result_ready, tx_data, tx_valid, busy, frame_done
  );

  modport slave (
    input  result, result_neg, result_err, result_valid, tx_ready,
    output result_ready, tx_data, tx_valid, busy, frame_done
  );
endinterface

// File: rtl/result_encoder_msd_finder.sv
// msd_finder: combinational priority encoder giving the index of the most
// significant nonzero nibble of a packed digit word, plus an all-zero flag.
module msd_finder #(
  parameter int DIGITS = 8,
  parameter int IW     = 3
) (
  input  logic [4*DIGITS-1:0] i_result,
  output logic [IW-1:0]       o_idx,
  output logic                o_all_zero
);

  // NOTE: defaults assigned before the loop so every path drives the outputs
  // and no latch is inferred.
  always_comb begin
    o_idx      = '0;
    o_all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_result[4*i +: 4] != 4'h0) begin
        o_idx      = IW'(i);
        o_all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/result_encoder.sv
// result_encoder: streams one captured result as an ASCII frame
// "R <sign><digits>|E <term>". Define RESULT_ENC_CRLF_EN for a CR LF terminator,
// otherwise the frame ends with LF only.
module result_encoder
  import calc_pkg::*;
#(
  parameter int         DIGITS    = 8,
  parameter logic [7:0] HEAD_CHAR = ASC_R
) (
  input logic             clk,
  input logic             rst,
  result_encoder_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef RESULT_ENC_CRLF_EN
  localparam enc_state_e TERM_STATE = S_CR;
  localparam logic [7:0] TERM_BYTE  = ASC_CR;
`else
  localparam enc_state_e TERM_STATE = S_LF;
  localparam logic [7:0] TERM_BYTE  = ASC_LF;
`endif

  enc_state_e          r_state;
  logic [4*DIGITS-1:0] r_result;
  logic                r_neg;
  logic                r_err;
  logic [IW-1:0]       r_cnt;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;

  logic [IW-1:0]       w_msd;
  logic                w_all_zero;
  logic                w_xfer;
  logic [IW-1:0]       w_cnt_m1;
  logic [3:0]          w_cur_nib;
  logic [3:0]          w_next_nib;

  msd_finder #(.DIGITS(DIGITS), .IW(IW)) u_msd (
    .i_result   (bus.result),
    .o_idx      (w_msd),
    .o_all_zero (w_all_zero)
  );

  assign w_xfer     = r_tx_valid && bus.tx_ready;
  assign w_cnt_m1   = r_cnt - 1'b1;
  assign w_cur_nib  = r_result[4*r_cnt +: 4];
  assign w_next_nib = r_result[4*w_cnt_m1 +: 4];

  // NOTE: state is updated with non-blocking assignments only; the async reset
  // also clears the captured result so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_neg      <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.result_valid && r_ready) begin
          r_result   <= bus.result;
          r_neg      <= bus.result_neg;
          r_err      <= bus.result_err;
          r_cnt      <= w_all_zero ? '0 : w_msd;
          r_state    <= S_HEAD;
          r_tx_data  <= HEAD_CHAR;
          r_tx_valid <= 1'b1;
          r_ready    <= 1'b0;
          r_busy     <= 1'b1;
        end
      end else if (w_xfer) begin
        // Each state already presents its byte; on transfer load the next one.
        case (r_state)
          S_HEAD: begin
            r_state   <= S_SPACE;
            r_tx_data <= ASC_SPACE;
          end
          S_SPACE: begin
            if (r_err) begin
              r_state   <= S_ERR;
              r_tx_data <= ASC_E;
            end else if (r_neg) begin
              r_state   <= S_SIGN;
              r_tx_data <= ASC_MINUS;
            end else begin
              r_state   <= S_DIGIT;
              r_tx_data <= nibble_ascii(w_cur_nib);
            end
          end
          S_SIGN: begin
            r_state   <= S_DIGIT;
            r_tx_data <= nibble_ascii(w_cur_nib);
          end
          S_DIGIT: begin
            if (r_cnt == '0) begin
              r_state   <= TERM_STATE;
              r_tx_data <= TERM_BYTE;
            end else begin
              r_cnt     <= w_cnt_m1;
              r_tx_data <= nibble_ascii(w_next_nib);
            end
          end
          S_ERR: begin
            r_state   <= TERM_STATE;
            r_tx_data <= TERM_BYTE;
          end
          S_CR: begin
            r_state   <= S_LF;
            r_tx_data <= ASC_LF;
          end
          S_LF: begin
            r_state    <= S_IDLE;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.result_ready = r_ready;
  assign bus.tx_data      = r_tx_data;
  assign bus.tx_valid     = r_tx_valid;
  assign bus.busy         = r_busy;
  assign bus.frame_done   = r_done;

endmodule

// File: tb/tb_result_encoder.sv
// Self-checking bench for result_encoder: directed and random frames compared
// against a digit-by-digit reference model of the ASCII frame format.
module tb_result_encoder;

  localparam int DIGITS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_encoder_if #(.DIGITS(DIGITS)) bus ();

  result_encoder #(.DIGITS(DIGITS), .HEAD_CHAR(8'h52)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Reference frame built from the format rules with plain arithmetic.
  function automatic void build_expected(input logic [31:0] r, input bit neg, input bit err);
    longint unsigned v;
    int n;
    bit started;
    exp_q.delete();
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h20);
    if (err) begin
      exp_q.push_back(8'h45);
    end else begin
      if (neg) exp_q.push_back(8'h2D);
      v = r;
      started = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        n = int'((v / (64'd1 << (4 * i))) % 16);
        if (n != 0 || started || i == 0) begin
          started = 1'b1;
          if (n < 10) exp_q.push_back(8'(48 + n));
          else        exp_q.push_back(8'(65 + n - 10));
        end
      end
    end
`ifdef RESULT_ENC_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.result = '0;
    bus.result_neg = 1'b0;
    bus.result_err = 1'b0;
    bus.result_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.result_ready !== 1'b1 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 ||
        bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b data=%h busy=%b done=%b expected 1 0 00 0 0",
               bus.result_ready, bus.tx_valid, bus.tx_data, bus.busy, bus.frame_done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: tx_ready always 1; 1: random tx_ready; 2: stall 3 cycles on '2'.
  task automatic run_frame(input logic [31:0] r, input bit neg, input bit err,
                           input int mode, input string name);
    logic [7:0] got[$];
    logic [7:0] last_data;
    bit last_stall;
    bit done;
    int cycles;
    int stall;
    build_expected(r, neg, err);
    bus.result = r;
    bus.result_neg = neg;
    bus.result_err = err;
    bus.result_valid = 1'b1;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    bus.result_valid = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h52) begin
      errors++;
      $display("FAIL %s latency: got vld=%b data=%h expected 1 52", name, bus.tx_valid, bus.tx_data);
    end
    got.delete();
    last_stall = 1'b0;
    last_data = 8'h00;
    done = 1'b0;
    cycles = 0;
    stall = 0;
    while (!done && cycles < 200) begin
      if (last_stall) begin
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== last_data) begin
          errors++;
          $display("FAIL %s hold: got vld=%b data=%h expected 1 %h", name, bus.tx_valid, bus.tx_data, last_data);
        end
      end
      case (mode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.tx_data == 8'h32 && stall < 3) begin
            bus.tx_ready = 1'b0;
            stall++;
          end else begin
            bus.tx_ready = 1'b1;
          end
        end
      endcase
      // A result offered mid-frame must be ignored.
      bus.result_valid = (cycles == 2);
      bus.result = $urandom;
      bus.result_neg = 1'($urandom_range(0, 1));
      bus.result_err = 1'($urandom_range(0, 1));
      if (cycles == 2) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.result_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s busy: got busy=%b rdy=%b expected 1 0", name, bus.busy, bus.result_ready);
        end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
        got.push_back(bus.tx_data);
        if (bus.tx_data == 8'h0A || got.size() >= exp_q.size() + 4) done = 1'b1;
      end
      last_stall = (bus.tx_valid === 1'b1) && !bus.tx_ready;
      last_data = bus.tx_data;
      @(negedge clk);
      cycles++;
    end
    bus.result_valid = 1'b0;
    bus.tx_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got %0d bytes expected %0d", name, got.size(), exp_q.size());
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s length: got %0d expected %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte %0d: got %h expected %h", name, i, got[i], exp_q[i]);
      end
    end
    if (mode == 0) begin
      checks++;
      if (cycles != exp_q.size()) begin
        errors++;
        $display("FAIL %s throughput: got %0d cycles expected %0d", name, cycles, exp_q.size());
      end
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.result_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got done=%b rdy=%b busy=%b vld=%b expected 1 1 0 0",
               name, bus.frame_done, bus.result_ready, bus.busy, bus.tx_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b expected 0", name, bus.frame_done);
    end
  endtask

  task automatic test_directed();
    run_frame(32'h00001234, 1'b0, 1'b0, 0, "t1_1234");
    run_frame(32'h00000000, 1'b0, 1'b0, 0, "t2_zero");
    run_frame(32'h00000056, 1'b1, 1'b0, 0, "t3_neg56");
    run_frame(32'h0000ABCD, 1'b0, 1'b0, 0, "t3_abcd");
    run_frame(32'h00001234, 1'b1, 1'b1, 0, "t4_err");
    run_frame(32'hF0000009, 1'b0, 1'b0, 0, "full_width");
  endtask

  task automatic test_backpressure();
    run_frame(32'h00001234, 1'b0, 1'b0, 2, "t5_stall");
  endtask

  task automatic test_reset_mid_frame();
    int wait_cnt;
    bus.result = 32'h00001234;
    bus.result_neg = 1'b0;
    bus.result_err = 1'b0;
    bus.result_valid = 1'b1;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    wait_cnt = 0;
    while (bus.tx_data !== 8'h32 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    bus.tx_ready = 1'b0;
    checks++;
    if (bus.tx_data !== 8'h32) begin
      errors++;
      $display("FAIL t6_reach_digit: got %h expected 32", bus.tx_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.result_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL t6_abort: got vld=%b rdy=%b busy=%b data=%h expected 0 1 0 00",
               bus.tx_valid, bus.result_ready, bus.busy, bus.tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(32'h00001234, 1'b0, 1'b0, 0, "t6_after_rst");
  endtask

  task automatic test_random();
    logic [31:0] r;
    int lz;
    for (int k = 0; k < 24; k++) begin
      r = $urandom;
      lz = $urandom_range(0, DIGITS);
      if (lz == DIGITS) r = '0;
      else if (lz > 0) r = r & (32'hFFFF_FFFF >> (4 * lz));
      run_frame(r, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
